lcd_debug_pipeline: RTL and testbench

Single-clock LCD output path for the 480×272 RGB panel. A frame source fills a synchronous FIFO with 17-bit pixel words. The source is either the internal colour-bar generator or an external writer. A timing engine drains the FIFO and drives DE, HSYNC, VSYNC and RGB565. The block sits between the video memory controller and the panel pins and provides a known-good image for bring-up.

---
 rtl/lcd_debug_pkg.sv | 46 ++++
 rtl/lcd_sync_fifo.sv | 51 +++++
 rtl/lcd_debug_pipeline.sv | 199 +++++++++++++++++++
 tb/tb_lcd_debug_pipeline.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_debug_pkg.sv
// Shared constants for the LCD debug output path: timing defaults, pixel word layout,
// colour-bar table and reader FSM states.
package lcd_debug_pkg;

   localparam int DEF_SCREEN_WIDTH  = 480;
   localparam int DEF_SCREEN_HEIGHT = 272;
   localparam int DEF_H_FP          = 8;
   localparam int DEF_H_SYNC        = 4;
   localparam int DEF_H_BP          = 43;
   localparam int DEF_V_FP          = 8;
   localparam int DEF_V_SYNC        = 4;
   localparam int DEF_V_BP          = 12;
   localparam int DEF_FIFO_AW       = 4;

   localparam int WORD_W     = 17;
   localparam int MARKER_BIT = 16;
   localparam int R_MSB      = 15;
   localparam int R_LSB      = 11;
   localparam int G_MSB      = 10;
   localparam int G_LSB      = 5;
   localparam int B_MSB      = 4;
   localparam int B_LSB      = 0;

   typedef enum logic [1:0] {
      RD_SEEK    = 2'd0,
      RD_ARMED   = 2'd1,
      RD_DISPLAY = 2'd2
   } rd_state_t;

   // Eight vertical bars, left to right: white, yellow, cyan, green, magenta, red, blue, black.
   function automatic logic [15:0] bar_colour(input logic [2:0] idx);
      logic [15:0] c;
      case (idx)
         3'd0:    c = 16'hFFFF;
         3'd1:    c = 16'hFFE0;
         3'd2:    c = 16'h07FF;
         3'd3:    c = 16'h07E0;
         3'd4:    c = 16'hF81F;
         3'd5:    c = 16'hF800;
         3'd6:    c = 16'h001F;
         default: c = 16'h0000;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/lcd_sync_fifo.sv
// Single-clock first-word-fall-through FIFO: q shows the head word whenever empty is low.
module lcd_sync_fifo #(
   parameter int WIDTH = 17,
   parameter int AW    = 4
) (
   input  logic             PixelClk,
   input  logic             nRST,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] q,
   output logic             full,
   output logic             empty
);

   localparam int DEPTH = 1 << AW;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             wr_ok;
   logic             rd_ok;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign wr_ok = wr_en & ~full;
   assign rd_ok = rd_en & ~empty;
   assign q     = mem[rd_ptr];

   always_ff @(posedge PixelClk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/lcd_debug_pipeline.sv
// LCD output path: FIFO fed by an external writer or, with DEBUG_PATTERN_EN defined,
// by the internal colour-bar generator; a timing engine and reader FSM drain it to the panel.
//
// state      | meaning
// RD_SEEK    | discard words until a frame-start marker is at the FIFO head
// RD_ARMED   | marker at head, waiting for the first active pixel of a frame
// RD_DISPLAY | popping one word per active pixel
module lcd_debug_pipeline
   import lcd_debug_pkg::*;
#(
   parameter int LCD_SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
   parameter int LCD_SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
   parameter int H_FP              = DEF_H_FP,
   parameter int H_SYNC            = DEF_H_SYNC,
   parameter int H_BP              = DEF_H_BP,
   parameter int V_FP              = DEF_V_FP,
   parameter int V_SYNC            = DEF_V_SYNC,
   parameter int V_BP              = DEF_V_BP,
   parameter int FIFO_AW           = DEF_FIFO_AW
) (
   input  logic              PixelClk,
   input  logic              nRST,
   input  logic [WORD_W-1:0] ext_data,
   input  logic              ext_wr_en,
   output logic              ext_full,
   output logic              LCD_CLK,
   output logic              LCD_DE,
   output logic              LCD_HSYNC,
   output logic              LCD_VSYNC,
   output logic [4:0]        LCD_R,
   output logic [5:0]        LCD_G,
   output logic [4:0]        LCD_B,
   output logic              underrun
);

   localparam int H_TOTAL = H_SYNC + H_BP + LCD_SCREEN_WIDTH + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + LCD_SCREEN_HEIGHT + V_FP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_SYNC_E = HW'(H_SYNC);
   localparam logic [HW-1:0] H_ACT_S  = HW'(H_SYNC + H_BP);
   localparam logic [HW-1:0] H_ACT_E  = HW'(H_SYNC + H_BP + LCD_SCREEN_WIDTH);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_SYNC_E = VW'(V_SYNC);
   localparam logic [VW-1:0] V_ACT_S  = VW'(V_SYNC + V_BP);
   localparam logic [VW-1:0] V_ACT_E  = VW'(V_SYNC + V_BP + LCD_SCREEN_HEIGHT);

   logic [WORD_W-1:0] fifo_wr_data;
   logic              fifo_wr_en;
   logic              fifo_rd_en;
   logic [WORD_W-1:0] fifo_q;
   logic              fifo_full;
   logic              fifo_empty;

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          active;
   logic          first_pix;

   rd_state_t     state;
   rd_state_t     state_nxt;
   logic [15:0]   pix_rgb;
   logic          set_underrun;

   assign LCD_CLK  = PixelClk;
   assign ext_full = fifo_full;

   lcd_sync_fifo #(
      .WIDTH (WORD_W),
      .AW    (FIFO_AW)
   ) u_fifo (
      .PixelClk (PixelClk),
      .nRST     (nRST),
      .wr_en    (fifo_wr_en),
      .wr_data  (fifo_wr_data),
      .rd_en    (fifo_rd_en),
      .q        (fifo_q),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

`ifdef DEBUG_PATTERN_EN
   localparam int XW = $clog2(LCD_SCREEN_WIDTH);
   localparam int YW = $clog2(LCD_SCREEN_HEIGHT);
   localparam logic [XW-1:0] X_LAST = XW'(LCD_SCREEN_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(LCD_SCREEN_HEIGHT - 1);
   localparam logic [XW-1:0] BAR_W  = XW'(LCD_SCREEN_WIDTH / 8);

   logic [XW-1:0] gen_x;
   logic [YW-1:0] gen_y;
   logic [2:0]    bar_idx;
   logic          unused_ext;

   assign unused_ext   = ^{ext_data, ext_wr_en};
   assign bar_idx      = 3'(gen_x / BAR_W);
   assign fifo_wr_en   = ~fifo_full;
   assign fifo_wr_data = {(gen_x == '0) && (gen_y == '0), bar_colour(bar_idx)};

   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         gen_x <= '0;
         gen_y <= '0;
      end else if (!fifo_full) begin
         if (gen_x == X_LAST) begin
            gen_x <= '0;
            gen_y <= (gen_y == Y_LAST) ? '0 : gen_y + YW'(1);
         end else begin
            gen_x <= gen_x + XW'(1);
         end
      end
   end
`else
   assign fifo_wr_en   = ext_wr_en;
   assign fifo_wr_data = ext_data;
`endif

   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
         h_cnt <= h_cnt + HW'(1);
      end
   end

   assign active    = (h_cnt >= H_ACT_S) && (h_cnt < H_ACT_E) &&
                      (v_cnt >= V_ACT_S) && (v_cnt < V_ACT_E);
   assign first_pix = (h_cnt == H_ACT_S) && (v_cnt == V_ACT_S);

   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) state <= RD_SEEK;
      else       state <= state_nxt;
   end

   // A marker at the head mid-frame means the writer restarted; wait for the next frame.
   always_comb begin
      state_nxt    = state;
      fifo_rd_en   = 1'b0;
      pix_rgb      = '0;
      set_underrun = 1'b0;
      case (state)
         RD_SEEK: begin
            if (!fifo_empty) begin
               if (fifo_q[MARKER_BIT]) state_nxt  = RD_ARMED;
               else                    fifo_rd_en = 1'b1;
            end
         end
         RD_ARMED: begin
            if (first_pix) begin
               fifo_rd_en = 1'b1;
               pix_rgb    = fifo_q[15:0];
               state_nxt  = RD_DISPLAY;
            end
         end
         RD_DISPLAY: begin
            if (active) begin
               if (fifo_empty) begin
                  set_underrun = 1'b1;
                  state_nxt    = RD_SEEK;
               end else if (fifo_q[MARKER_BIT] && !first_pix) begin
                  state_nxt = RD_ARMED;
               end else if (first_pix && !fifo_q[MARKER_BIT]) begin
                  state_nxt = RD_SEEK;
               end else begin
                  fifo_rd_en = 1'b1;
                  pix_rgb    = fifo_q[15:0];
               end
            end
         end
         default: state_nxt = RD_SEEK;
      endcase
   end

   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         LCD_DE    <= 1'b0;
         LCD_HSYNC <= 1'b1;
         LCD_VSYNC <= 1'b1;
         LCD_R     <= '0;
         LCD_G     <= '0;
         LCD_B     <= '0;
         underrun  <= 1'b0;
      end else begin
         LCD_DE    <= active;
         LCD_HSYNC <= (h_cnt >= H_SYNC_E);
         LCD_VSYNC <= (v_cnt >= V_SYNC_E);
         LCD_R     <= pix_rgb[R_MSB:R_LSB];
         LCD_G     <= pix_rgb[G_MSB:G_LSB];
         LCD_B     <= pix_rgb[B_MSB:B_LSB];
         underrun  <= underrun | set_underrun;
      end
   end

endmodule

// File: tb/tb_lcd_debug_pipeline.sv
// Self-checking bench for lcd_debug_pipeline on a reduced panel geometry; a frame-level
// queue model predicts every output pixel, sync level and the underrun flag.
module tb_lcd_debug_pipeline;

   localparam int W   = 32;
   localparam int H   = 8;
   localparam int HFP = 2;
   localparam int HSW = 2;
   localparam int HBP = 3;
   localparam int VFP = 1;
   localparam int VSW = 1;
   localparam int VBP = 2;
   localparam int HT  = HSW + HBP + W + HFP;
   localparam int VT  = VSW + VBP + H + VFP;
   localparam int FT  = HT * VT;
   localparam int HA  = HSW + HBP;
   localparam int VA  = VSW + VBP;

   localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                        16'hF81F, 16'hF800, 16'h001F, 16'h0000};

   logic        PixelClk = 1'b0;
   logic        nRST = 1'b0;
   logic [16:0] ext_data = '0;
   logic        ext_wr_en = 1'b0;
   logic        ext_full, LCD_CLK, LCD_DE, LCD_HSYNC, LCD_VSYNC, underrun;
   logic [4:0]  LCD_R, LCD_B;
   logic [5:0]  LCD_G;

   typedef struct packed { logic [16:0] w; logic keep; logic force_wr; } src_t;

   src_t        src_q[$];
   logic [16:0] exp_q[$];
   int          compared = 0;
   int          mismatched = 0;
   int          cyc;
   bit          disp_m, ur_m, pend;
   logic [16:0] pend_w;
   int          g_h, g_v;
   bit          g_de, g_valid;

   lcd_debug_pipeline #(
      .LCD_SCREEN_WIDTH (W), .LCD_SCREEN_HEIGHT (H),
      .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
      .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP), .FIFO_AW (4)
   ) dut (
      .PixelClk (PixelClk), .nRST (nRST), .ext_data (ext_data), .ext_wr_en (ext_wr_en),
      .ext_full (ext_full), .LCD_CLK (LCD_CLK), .LCD_DE (LCD_DE),
      .LCD_HSYNC (LCD_HSYNC), .LCD_VSYNC (LCD_VSYNC),
      .LCD_R (LCD_R), .LCD_G (LCD_G), .LCD_B (LCD_B), .underrun (underrun)
   );

   always #5 PixelClk = ~PixelClk;

   always @(posedge PixelClk or negedge nRST) begin
      if (!nRST) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic clear_model();
      src_q.delete();
      exp_q.delete();
      disp_m    = 0;
      ur_m      = 0;
      pend      = 0;
      ext_wr_en = 1'b0;
      ext_data  = '0;
   endtask

   // One clock: sample at the falling edge, compare against the model, then drive the writer.
   task automatic step();
      logic [15:0] rgb, exp_rgb;
      logic [16:0] wtmp;
      logic [2:0]  e_sync;
      int s, px, py;
      @(negedge PixelClk);
      rgb     = {LCD_R, LCD_G, LCD_B};
      g_valid = 0;
      g_de    = 0;
      if (!nRST) begin
         compared++;
         if ({LCD_DE, LCD_HSYNC, LCD_VSYNC, underrun, ext_full} !== 5'b01100 || rgb !== 16'h0) begin
            mismatched++;
            $display("FAIL reset_values: de,hs,vs,ur,full=%b rgb=%h, required 01100 rgb=0000",
                     {LCD_DE, LCD_HSYNC, LCD_VSYNC, underrun, ext_full}, rgb);
         end
      end else if (cyc >= 1) begin
         s       = cyc - 1;
         g_h     = s % HT;
         g_v     = (s / HT) % VT;
         g_valid = 1;
         g_de    = (g_h >= HA) && (g_h < HA + W) && (g_v >= VA) && (g_v < VA + H);
         e_sync  = {g_de, g_h >= HSW, g_v >= VSW};
         compared++;
         if ({LCD_DE, LCD_HSYNC, LCD_VSYNC} !== e_sync) begin
            mismatched++;
            $display("FAIL sync_timing cyc=%0d: de,hs,vs=%b, required %b", cyc,
                     {LCD_DE, LCD_HSYNC, LCD_VSYNC}, e_sync);
         end
         exp_rgb = '0;
         if (g_de) begin
            px = g_h - HA;
            py = g_v - VA;
            if (px == 0 && py == 0) disp_m = (exp_q.size() > 0) && exp_q[0][16];
            if (disp_m) begin
               if (exp_q.size() == 0) begin
                  ur_m   = 1;
                  disp_m = 0;
               end else if (exp_q[0][16] && !(px == 0 && py == 0)) begin
                  disp_m = 0;
               end else begin
                  wtmp    = exp_q.pop_front();
                  exp_rgb = wtmp[15:0];
               end
            end
         end
         compared++;
         if (rgb !== exp_rgb) begin
            mismatched++;
            $display("FAIL pixel_rgb cyc=%0d h=%0d v=%0d: got %h, required %h", cyc, g_h, g_v, rgb, exp_rgb);
         end
         compared++;
         if (underrun !== ur_m) begin
            mismatched++;
            $display("FAIL underrun_flag cyc=%0d: got %b, required %b", cyc, underrun, ur_m);
         end
      end
      if (pend) exp_q.push_back(pend_w);
      pend = 0;
      if (nRST && src_q.size() > 0 && (!ext_full || src_q[0].force_wr)) begin
         ext_data  = src_q[0].w;
         ext_wr_en = 1'b1;
         if (src_q[0].keep) begin
            pend   = 1;
            pend_w = src_q[0].w;
         end
         void'(src_q.pop_front());
      end else begin
         ext_wr_en = 1'b0;
         ext_data  = '0;
      end
   endtask

   task automatic do_reset(int n);
      nRST = 1'b0;
      clear_model();
      repeat (n) step();
      nRST = 1'b1;
   endtask

   task automatic make_frame(bit bars, int nwords, bit keep);
      src_t        e;
      logic [31:0] r;
      logic [15:0] col;
      for (int i = 0; i < nwords; i++) begin
         r   = $urandom();
         col = bars ? BARS[(i % W) / (W / 8)] : r[15:0];
         e.w = {i == 0, col};
         e.keep = keep;
         e.force_wr = 0;
         src_q.push_back(e);
      end
   endtask

   task automatic test_reset();
      do_reset(10);
   endtask

   task automatic test_timing();
      int first_de = -1;
      int lines = 0;
      int line_de [VT];
      int total = 0;
      for (int i = 0; i < VT; i++) line_de[i] = 0;
      for (int i = 0; i < FT; i++) begin
         step();
         if (LCD_DE === 1'b1) begin
            if (first_de < 0) first_de = cyc;
            if (g_valid) line_de[g_v]++;
            total++;
         end
      end
      compared++;
      if (first_de != VA * HT + HA + 1) begin
         mismatched++;
         $display("FAIL first_de_cycle: got %0d, required %0d", first_de, VA * HT + HA + 1);
      end
      for (int i = 0; i < VT; i++) if (line_de[i] == W) lines++;
      compared++;
      if (lines != H || total != W * H) begin
         mismatched++;
         $display("FAIL de_per_frame: full lines %0d total %0d, required %0d and %0d", lines, total, H, W * H);
      end
   endtask

   task automatic check_pixel(string name, int x, int y, logic [15:0] req);
      if (g_valid && g_de && g_h == HA + x && g_v == VA + y && cyc < FT) begin
         compared++;
         if ({LCD_R, LCD_G, LCD_B} !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, {LCD_R, LCD_G, LCD_B}, req);
         end
      end
   endtask

   task automatic test_end_flag(string name, bit req);
      compared++;
      if (underrun !== req) begin
         mismatched++;
         $display("FAIL %s: underrun %b, required %b", name, underrun, req);
      end
   endtask

`ifdef DEBUG_PATTERN_EN
   task automatic test_pattern();
      logic [16:0] w;
      do_reset(3);
      for (int f = 0; f < 2; f++)
         for (int i = 0; i < W * H; i++) begin
            w = {i == 0, BARS[(i % W) / (W / 8)]};
            exp_q.push_back(w);
         end
      while (cyc < 2 * FT) begin
         step();
         check_pixel("pattern_px0", 0, 0, 16'hFFFF);
         check_pixel("pattern_bar1", W / 8, 0, 16'hFFE0);
         check_pixel("pattern_last", W - 1, 0, 16'h0000);
      end
      test_end_flag("pattern_underrun", 0);
   endtask
`else
   task automatic test_stream();
      do_reset(3);
      make_frame(1, W * H, 1);
      make_frame(0, W * H, 1);
      while (cyc < 2 * FT) begin
         step();
         check_pixel("stream_px0", 0, 0, 16'hFFFF);
         check_pixel("stream_bar1", W / 8, 0, 16'hFFE0);
         check_pixel("stream_last", W - 1, 0, 16'h0000);
      end
      test_end_flag("stream_underrun", 0);
   endtask

   task automatic test_seek_discard();
      src_t e;
      logic [16:0] marker;
      do_reset(3);
      for (int i = 0; i < 5; i++) begin
         e.w = {1'b0, 16'h1234 + 16'(i)};
         e.keep = 0;
         e.force_wr = 0;
         src_q.push_back(e);
      end
      make_frame(0, W * H, 1);
      marker = src_q[5].w;
      while (cyc < FT) begin
         step();
         check_pixel("seek_marker_px", 0, 0, marker[15:0]);
      end
      test_end_flag("seek_underrun", 0);
   endtask

   task automatic test_underrun();
      bit queued = 0;
      do_reset(3);
      make_frame(0, 5 * W + W / 2, 1);
      while (cyc < 2 * FT) begin
         step();
         if (ur_m && !queued) begin
            make_frame(0, W * H, 1);
            queued = 1;
         end
      end
      test_end_flag("underrun_sticky", 1);
   endtask

   task automatic test_fifo();
      src_t e;
      logic [31:0] r;
      do_reset(3);
      for (int i = 0; i < 17; i++) begin
         r = $urandom();
         e.w = {1'b1, r[15:0]};
         e.keep = (i < 16);
         e.force_wr = 1;
         src_q.push_back(e);
      end
      for (int k = 1; k <= 20; k++) begin
         step();
         compared++;
         if (ext_full !== (k >= 17)) begin
            mismatched++;
            $display("FAIL fifo_full step %0d: got %b, required %b", k, ext_full, k >= 17);
         end
      end
      while (cyc < 16 * FT + VA * HT + HA + 5) step();
      compared++;
      if (ext_full !== 1'b0) begin
         mismatched++;
         $display("FAIL fifo_drained_full: got %b, required 0", ext_full);
      end
      test_end_flag("fifo_underrun_after_16", 1);
   endtask

   task automatic test_midframe_reset();
      bit found = 0;
      do_reset(3);
      for (int f = 0; f < 3; f++) make_frame(0, W * H, 1);
      for (int i = 0; i < FT && !found; i++) begin
         step();
         if (g_valid && g_de && g_v == VA + 3) found = 1;
      end
      compared++;
      if (!found) begin
         mismatched++;
         $display("FAIL midframe_reach: reached 0, required 1");
      end
      @(posedge PixelClk);
      #2 nRST = 1'b0;
      #1;
      compared++;
      if ({LCD_DE, LCD_HSYNC, LCD_VSYNC, underrun, ext_full, LCD_R, LCD_G, LCD_B} !== {5'b01100, 16'h0}) begin
         mismatched++;
         $display("FAIL async_reset: de,hs,vs,ur,full=%b rgb=%h, required 01100 rgb=0000",
                  {LCD_DE, LCD_HSYNC, LCD_VSYNC, underrun, ext_full}, {LCD_R, LCD_G, LCD_B});
      end
      do_reset(3);
      make_frame(0, W * H, 1);
      while (cyc < FT) step();
      test_end_flag("midframe_resume_underrun", 0);
   endtask
`endif

   initial begin
      test_reset();
      test_timing();
`ifdef DEBUG_PATTERN_EN
      test_pattern();
`else
      test_stream();
      test_seek_discard();
      test_underrun();
      test_fifo();
      test_midframe_reset();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
